eth_tx_sched: RTL and testbench

ETH_TX_SCHED -- requirements
Module: eth_tx_sched

---
 rtl/eth_tx_sched.sv | 170 +++++++++++++++++
 tb/tb_eth_tx_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_sched.sv
// eth_tx_sched: arbitrates ARP replies, self-generated ARP requests and UDP
// frames onto a single transmit datapath via a tx_fs/tx_fd handshake.
// Optional feature macro: ETH_TX_SCHED_IFG_EN (inter-frame gap state).
module eth_tx_sched #(
   parameter int unsigned IFG_CYCLES  = 12,
   parameter logic [15:0] ARP_HOLDOFF = 16'd1000,
   parameter logic [15:0] MAX_LEN     = 16'd1472
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arp_reply_req,
   output logic        arp_reply_ack,
   input  logic        udp_req,
   input  logic [15:0] udp_len,
   output logic        udp_ack,
   output logic        len_err,
   input  logic        dst_mac_valid,
   output logic        tx_fs,
   input  logic        tx_fd,
   output logic [15:0] mac_mode,
   output logic [7:0]  ip_mode,
   output logic        arp_req,
   output logic [15:0] data_len,
   output logic        busy
);

   localparam logic [15:0] ETH_IP  = 16'h0800;
   localparam logic [15:0] ETH_ARP = 16'h0806;
   localparam logic [7:0]  IP_UDP  = 8'h11;

`ifdef ETH_TX_SCHED_IFG_EN
   localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE, S_IFG} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
`endif

   typedef enum logic [1:0] {G_REPLY, G_AREQ, G_UDP} grant_t;

   state_t      state_q;
   grant_t      grant_q;
   logic [15:0] holdoff_q;
   logic        tx_fs_q;
   logic        arp_reply_ack_q;
   logic        udp_ack_q;
   logic        len_err_q;
   logic        busy_q;
   logic [15:0] mac_mode_q;
   logic [7:0]  ip_mode_q;
   logic        arp_req_q;
   logic [15:0] data_len_q;
`ifdef ETH_TX_SCHED_IFG_EN
   logic [GAP_W-1:0] gap_q;
`endif

   // Requests already acked this cycle are masked so a requester that has not
   // yet dropped its level is not served twice.
   logic reply_req_c;
   logic udp_req_c;
   logic len_bad_c;
   assign reply_req_c = arp_reply_req && !arp_reply_ack_q;
   assign udp_req_c   = udp_req && !udp_ack_q;
   assign len_bad_c   = (udp_len == 16'd0) || (udp_len > MAX_LEN);

   // Scheduler FSM, holdoff timer and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         grant_q         <= G_UDP;
         holdoff_q       <= 16'd0;
         tx_fs_q         <= 1'b0;
         arp_reply_ack_q <= 1'b0;
         udp_ack_q       <= 1'b0;
         len_err_q       <= 1'b0;
         busy_q          <= 1'b0;
         mac_mode_q      <= ETH_IP;
         ip_mode_q       <= IP_UDP;
         arp_req_q       <= 1'b0;
         data_len_q      <= 16'd0;
`ifdef ETH_TX_SCHED_IFG_EN
         gap_q           <= '0;
`endif
      end else begin
         arp_reply_ack_q <= 1'b0;
         udp_ack_q       <= 1'b0;
         len_err_q       <= 1'b0;
         ip_mode_q       <= IP_UDP;
         if (holdoff_q != 16'd0) holdoff_q <= holdoff_q - 16'd1;

         case (state_q)
            S_IDLE: begin
               if (reply_req_c) begin
                  grant_q    <= G_REPLY;
                  mac_mode_q <= ETH_ARP;
                  arp_req_q  <= 1'b0;
                  data_len_q <= 16'd0;
                  tx_fs_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= S_SEND;
               end else if (udp_req_c && len_bad_c) begin
                  udp_ack_q <= 1'b1;
                  len_err_q <= 1'b1;
               end else if (udp_req_c && !dst_mac_valid && holdoff_q == 16'd0) begin
                  grant_q    <= G_AREQ;
                  mac_mode_q <= ETH_ARP;
                  arp_req_q  <= 1'b1;
                  data_len_q <= 16'd0;
                  tx_fs_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  holdoff_q  <= ARP_HOLDOFF;
                  state_q    <= S_SEND;
               end else if (udp_req_c && dst_mac_valid) begin
                  grant_q    <= G_UDP;
                  mac_mode_q <= ETH_IP;
                  arp_req_q  <= 1'b0;
                  data_len_q <= udp_len;
                  tx_fs_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= S_SEND;
               end
            end
            S_SEND: begin
               if (tx_fd) begin
                  tx_fs_q         <= 1'b0;
                  arp_reply_ack_q <= (grant_q == G_REPLY);
                  udp_ack_q       <= (grant_q == G_UDP);
                  state_q         <= S_DONE;
               end
            end
            S_DONE: begin
               if (!tx_fd) begin
`ifdef ETH_TX_SCHED_IFG_EN
                  gap_q   <= GAP_W'(IFG_CYCLES - 1);
                  state_q <= S_IFG;
`else
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
`endif
               end
            end
`ifdef ETH_TX_SCHED_IFG_EN
            S_IFG: begin
               if (gap_q == '0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q - GAP_W'(1);
               end
            end
`endif
            default: begin
               tx_fs_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_fs         = tx_fs_q;
   assign arp_reply_ack = arp_reply_ack_q;
   assign udp_ack       = udp_ack_q;
   assign len_err       = len_err_q;
   assign busy          = busy_q;
   assign mac_mode      = mac_mode_q;
   assign ip_mode       = ip_mode_q;
   assign arp_req       = arp_req_q;
   assign data_len      = data_len_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: stimulus pushes expected frames/acks,
// a negedge monitor pops and compares whenever the DUT starts a frame or acks.
module tb_eth_tx_sched;

   localparam logic [15:0] HOLD = 16'd1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arp_reply_req = 1'b0;
   logic        arp_reply_ack;
   logic        udp_req = 1'b0;
   logic [15:0] udp_len = 16'd0;
   logic        udp_ack;
   logic        len_err;
   logic        dst_mac_valid = 1'b0;
   logic        tx_fs;
   logic        tx_fd = 1'b0;
   logic [15:0] mac_mode;
   logic [7:0]  ip_mode;
   logic        arp_req;
   logic [15:0] data_len;
   logic        busy;

   eth_tx_sched #(.IFG_CYCLES(12), .ARP_HOLDOFF(HOLD), .MAX_LEN(16'd1472)) dut (
      .clk(clk), .rst(rst),
      .arp_reply_req(arp_reply_req), .arp_reply_ack(arp_reply_ack),
      .udp_req(udp_req), .udp_len(udp_len), .udp_ack(udp_ack), .len_err(len_err),
      .dst_mac_valid(dst_mac_valid), .tx_fs(tx_fs), .tx_fd(tx_fd),
      .mac_mode(mac_mode), .ip_mode(ip_mode), .arp_req(arp_req),
      .data_len(data_len), .busy(busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   typedef struct packed {
      logic [15:0] mac;
      logic        areq;
      logic [15:0] len;
   } frm_t;

   frm_t        exp_frm[$];
   logic [2:0]  exp_ack[$];   // {arp_reply_ack, udp_ack, len_err}
   int unsigned areq_cyc[$];

   // Transmit datapath model: completes a frame a few cycles after tx_fs.
   logic fd_hold = 1'b0;
   int   fd_cnt  = 0;
   always @(negedge clk) begin
      if (rst) begin
         tx_fd  = 1'b0;
         fd_cnt = 0;
      end else if (tx_fd) begin
         tx_fd  = 1'b0;
         fd_cnt = 0;
      end else if (tx_fs && !fd_hold) begin
         if (fd_cnt == 3) tx_fd = 1'b1;
         else fd_cnt++;
      end
   end

   // Monitor: frame starts, attribute stability while busy, and ack pulses.
   logic       fs_prev = 1'b0;
   logic       cap_v   = 1'b0;
   frm_t       cap;
   frm_t       mon_e;
   logic [2:0] mon_a;
   always @(negedge clk) begin
      if (rst) begin
         fs_prev = 1'b0;
         cap_v   = 1'b0;
      end else begin
         if (tx_fs && !fs_prev) begin
            if (exp_frm.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: mac 0x%0h len %0d at cycle %0d", mac_mode, data_len, cyc);
            end else begin
               mon_e = exp_frm.pop_front();
               chk("frame_mac_mode", 48'(mac_mode), 48'(mon_e.mac));
               chk("frame_arp_req", 48'(arp_req), 48'(mon_e.areq));
               chk("frame_data_len", 48'(data_len), 48'(mon_e.len));
               chk("frame_ip_mode", 48'(ip_mode), 48'(8'h11));
            end
            cap   = '{mac: mac_mode, areq: arp_req, len: data_len};
            cap_v = 1'b1;
            if (arp_req) areq_cyc.push_back(cyc);
         end else if (busy && cap_v) begin
            chk("attr_stable", 48'({mac_mode, arp_req, data_len}), 48'(cap));
         end
         if (!busy && !tx_fs) cap_v = 1'b0;
         if (arp_reply_ack || udp_ack || len_err) begin
            if (exp_ack.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: bits %b at cycle %0d", {arp_reply_ack, udp_ack, len_err}, cyc);
            end else begin
               mon_a = exp_ack.pop_front();
               chk("ack_bits", 48'({arp_reply_ack, udp_ack, len_err}), 48'(mon_a));
            end
         end
         fs_prev = tx_fs;
      end
   end

   // One cycle of requester behaviour: drop a level once its ack is seen.
   task automatic step();
      @(negedge clk);
      if (udp_ack) udp_req = 1'b0;
      if (arp_reply_ack) arp_reply_req = 1'b0;
   endtask

   task automatic quiet(input string name, input int max);
      bool_done: begin
         for (int i = 0; i < max; i++) begin
            step();
            if (!udp_req && !arp_reply_req && !busy) disable bool_done;
         end
         chk({name, "_timeout"}, 48'(1), 48'(0));
      end
   endtask

   task automatic udp(input logic [15:0] len, input logic dv);
      udp_len       = len;
      dst_mac_valid = dv;
      udp_req       = 1'b1;
   endtask

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_tx_fs", 48'(tx_fs), 48'(0));
      chk("rst_busy", 48'(busy), 48'(0));
      chk("rst_mac_mode", 48'(mac_mode), 48'(16'h0800));
      chk("rst_ip_mode", 48'(ip_mode), 48'(8'h11));
      chk("rst_arp_req", 48'(arp_req), 48'(0));
      chk("rst_data_len", 48'(data_len), 48'(0));
      chk("rst_acks", 48'({arp_reply_ack, udp_ack, len_err}), 48'(0));
      rst = 1'b0;
      step();

      // Plain UDP frame, one-cycle grant latency
      exp_frm.push_back('{mac: 16'h0800, areq: 1'b0, len: 16'd64});
      exp_ack.push_back(3'b010);
      udp(16'd64, 1'b1);
      step();
      chk("udp_fs_latency", 48'(tx_fs), 48'(1));
      chk("udp_busy", 48'(busy), 48'(1));
      quiet("udp64", 100);

      // Simultaneous reply and UDP: reply wins
      exp_frm.push_back('{mac: 16'h0806, areq: 1'b0, len: 16'd0});
      exp_ack.push_back(3'b100);
      exp_frm.push_back('{mac: 16'h0800, areq: 1'b0, len: 16'd100});
      exp_ack.push_back(3'b010);
      arp_reply_req = 1'b1;
      udp(16'd100, 1'b1);
      quiet("prio", 200);

      // Length boundaries
      exp_ack.push_back(3'b011);
      udp(16'd0, 1'b1);
      quiet("len0", 20);
      exp_ack.push_back(3'b011);
      udp(16'd1473, 1'b1);
      quiet("len1473", 20);
      exp_frm.push_back('{mac: 16'h0800, areq: 1'b0, len: 16'd1472});
      exp_ack.push_back(3'b010);
      udp(16'd1472, 1'b1);
      quiet("len1472", 100);

      // Unresolved MAC: ARP request, holdoff, reply not blocked, then UDP
      exp_frm.push_back('{mac: 16'h0806, areq: 1'b1, len: 16'd0});
      udp(16'd200, 1'b0);
      for (int i = 0; i < 20 && areq_cyc.size() < 1; i++) step();
      chk("areq_first_seen", 48'(areq_cyc.size()), 48'(1));
      repeat (100) step();
      chk("udp_still_pending", 48'(udp_req), 48'(1));
      exp_frm.push_back('{mac: 16'h0806, areq: 1'b0, len: 16'd0});
      exp_ack.push_back(3'b100);
      exp_frm.push_back('{mac: 16'h0806, areq: 1'b1, len: 16'd0});
      arp_reply_req = 1'b1;
      for (int i = 0; i < 1200 && areq_cyc.size() < 2; i++) step();
      chk("areq_second_seen", 48'(areq_cyc.size()), 48'(2));
      if (areq_cyc.size() >= 2)
         chk("holdoff_interval", 48'(areq_cyc[1] - areq_cyc[0]), 48'(32'(HOLD) + 1));
      exp_frm.push_back('{mac: 16'h0800, areq: 1'b0, len: 16'd200});
      exp_ack.push_back(3'b010);
      dst_mac_valid = 1'b1;
      quiet("resolved", 100);

      // Reset mid-frame: no ack, grant discarded, request re-arbitrated
      fd_hold = 1'b1;
      exp_frm.push_back('{mac: 16'h0800, areq: 1'b0, len: 16'd64});
      udp(16'd64, 1'b1);
      for (int i = 0; i < 10 && !tx_fs; i++) step();
      chk("rst_mid_fs_seen", 48'(tx_fs), 48'(1));
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rst_mid_tx_fs", 48'(tx_fs), 48'(0));
      chk("rst_mid_busy", 48'(busy), 48'(0));
      chk("rst_mid_mac_mode", 48'(mac_mode), 48'(16'h0800));
      chk("rst_mid_data_len", 48'(data_len), 48'(0));
      chk("rst_mid_acks", 48'({arp_reply_ack, udp_ack, len_err}), 48'(0));
      exp_frm.push_back('{mac: 16'h0800, areq: 1'b0, len: 16'd64});
      exp_ack.push_back(3'b010);
      fd_hold = 1'b0;
      step();
      step();
      rst = 1'b0;
      quiet("rearb", 100);

      repeat (5) step();
      chk("frm_queue_empty", 48'(exp_frm.size()), 48'(0));
      chk("ack_queue_empty", 48'(exp_ack.size()), 48'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
